ram_rd_ctrl: RTL and testbench

//  Read-side counterpart of the key-driven RAM write-address control: on a key press it

---
 rtl/ram_rd_ctrl.sv | 114 +++++++++++
 tb/tb_ram_rd_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ram_rd_ctrl.sv
// ram_rd_ctrl: key-started block reader that streams rd_len words from a synchronous-read RAM
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   key                     active-low start key (asynchronous, synchronised here)
//   base_addr, rd_len       block start address and word count, sampled on the start event
//   rd_en, rd_addr, rd_data RAM read port; rd_data valid RD_LAT cycles after rd_en
//   dout, dout_valid        show-ahead stream output (FIFO head)
//   dout_ready              consumer ready; a word pops on dout_valid & dout_ready
//   busy, done              transfer in progress / one-cycle completion pulse
module ram_rd_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   rd_len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done
);
    localparam int DEPTH = RD_LAT + 2;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
    logic              key_d0, key_d1, start;
    logic [1:0]        state;
    logic [ADDR_W-1:0] addr, last_addr;
    logic [ADDR_W:0]   remaining;
    logic [RD_LAT-1:0] vld;
    logic [DATA_W-1:0] fifo [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     fifo_count, in_flight;
    logic [CW:0]       used;
    logic              wr, pop, credit;

    assign start      = ~key_d0 & key_d1;
    assign wr         = vld[RD_LAT-1];
    assign dout_valid = fifo_count != '0;
    assign dout       = dout_valid ? fifo[rd_ptr] : '0;
    assign pop        = dout_valid & dout_ready;
    // credit counts every word already requested but not yet popped, so the FIFO cannot overflow
    assign used       = (CW+1)'(fifo_count) + (CW+1)'(in_flight);
    assign credit     = used < (CW+1)'(DEPTH);
    assign rd_en      = (state == READ) && credit;
    assign rd_addr    = rd_en ? addr : last_addr;
    assign busy       = state != IDLE;
    assign done       = state == DONE;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LAT; i++)
            in_flight = in_flight + CW'(vld[i]);
    end

    always_ff @(posedge clk) begin
        if (wr)
            fifo[wr_ptr] <= rd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_d0     <= 1'b1;
            key_d1     <= 1'b1;
            state      <= IDLE;
            addr       <= '0;
            last_addr  <= '0;
            remaining  <= '0;
            vld        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            key_d0     <= key;
            key_d1     <= key_d0;
            vld        <= RD_LAT'({vld, rd_en});
            fifo_count <= fifo_count + CW'(wr) - CW'(pop);
            if (wr)
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            if (rd_en) begin
                addr      <= addr + ADDR_W'(1);
                remaining <= remaining - (ADDR_W+1)'(1);
                last_addr <= addr;
            end
            case (state)
                IDLE:
                    if (start) begin
                        addr      <= base_addr;
                        remaining <= rd_len;
                        // an empty block passes through DRAIN so done lands two cycles after start
                        state     <= (rd_len == '0) ? DRAIN : READ;
                    end
                READ:
                    if (rd_en && remaining == (ADDR_W+1)'(1))
                        state <= DRAIN;
                // leave in the cycle of the final pop so done follows it directly
                DRAIN:
                    if (in_flight == '0 && (fifo_count == '0 || (fifo_count == CW'(1) && pop)))
                        state <= DONE;
                default:
                    state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_rd_ctrl.sv
// tb_ram_rd_ctrl: runs RD_LAT=1 and RD_LAT=3 controllers side by side against a word-level stream model
module tb_ram_rd_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, key, dout_ready;
    logic [4:0]  base_addr;
    logic [5:0]  rd_len;
    logic        rd_en [2];
    logic [4:0]  rd_addr [2];
    logic [15:0] rd_data [2];
    logic [15:0] dout [2];
    logic        dout_valid [2];
    logic        busy [2];
    logic        done [2];
    logic [15:0] mem [32];
    logic [15:0] q0;
    logic [15:0] q1 [3];
    logic [4:0]  last_a [2];
    int          passes = 0, fails = 0, total = 0, cn = 0;

    always #5 clk = ~clk;

    ram_rd_ctrl #(.ADDR_W(5), .DATA_W(16), .RD_LAT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .key(key), .base_addr(base_addr), .rd_len(rd_len),
        .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .dout(dout[0]),
        .dout_valid(dout_valid[0]), .dout_ready(dout_ready), .busy(busy[0]), .done(done[0])
    );
    ram_rd_ctrl #(.ADDR_W(5), .DATA_W(16), .RD_LAT(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .key(key), .base_addr(base_addr), .rd_len(rd_len),
        .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .dout(dout[1]),
        .dout_valid(dout_valid[1]), .dout_ready(dout_ready), .busy(busy[1]), .done(done[1])
    );

    // synchronous-read RAMs with 1 and 3 cycles of read latency
    always @(posedge clk) begin
        q0    <= mem[rd_addr[0]];
        q1[0] <= mem[rd_addr[1]];
        q1[1] <= q1[0];
        q1[2] <= q1[1];
    end
    assign rd_data[0] = q0;
    assign rd_data[1] = q1[2];

    task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s lat=%0d cycle=%0d: got %0d, expected %0d", tag, d ? 3 : 1, cn, obs, exp);
        end
    endtask

    // One key press at cycle 0 (start seen at cycle 1); optional second press at p2 and reset at rst_at.
    task automatic run(input int base, input int len, input int rmode, input int p2, input int rst_at);
        int issued [2], popped [2], last_pop [2], dcyc [2];
        int icyc [2][64];
        int n, lat;
        bit ab, ren, val, dn, bs;
        logic [4:0] a;
        for (int d = 0; d < 2; d++) begin
            issued[d] = 0; popped[d] = 0; last_pop[d] = -10; dcyc[d] = -1;
        end
        base_addr = 5'(base);
        rd_len = 6'(len);
        for (n = 0; n < 400; n++) begin
            @(posedge clk);
            #1;
            cn = n;
            key = !(n == 0 || n == p2);
            if (n == p2) begin
                base_addr = 5'($urandom);
                rd_len = 6'($urandom_range(1, 32));
            end
            dout_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (n % 4 == 0 || n % 4 == 3) : 1'($urandom_range(0, 1));
            if (rst_at >= 0)
                rst_n = !(n == rst_at || n == rst_at + 1);
            ab = rst_at >= 0 && n >= rst_at;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                lat = d ? 3 : 1;
                if (ab) begin
                    last_a[d] = '0;
                    check("rst_rd_en", d, rd_en[d], 0);
                    check("rst_rd_addr", d, rd_addr[d], 0);
                    check("rst_valid", d, dout_valid[d], 0);
                    check("rst_busy", d, busy[d], 0);
                    check("rst_done", d, done[d], 0);
                    if (!rst_n)
                        check("rst_dout", d, dout[d], 0);
                end else begin
                    ren = n >= 2 && issued[d] < len && issued[d] - popped[d] < lat + 2;
                    a = ren ? 5'(base + issued[d]) : last_a[d];
                    check("rd_en", d, rd_en[d], ren);
                    check("rd_addr", d, rd_addr[d], a);
                    if (ren) begin
                        icyc[d][issued[d]] = n;
                        issued[d]++;
                        last_a[d] = a;
                    end
                    val = popped[d] < issued[d] && icyc[d][popped[d]] + lat + 1 <= n;
                    check("dout_valid", d, dout_valid[d], val);
                    if (val)
                        check("dout", d, dout[d], mem[5'(base + popped[d])]);
                    dn = dcyc[d] < 0 && (len == 0 ? n == 3 : (popped[d] == len && last_pop[d] == n - 1));
                    check("done", d, done[d], dn);
                    if (dn)
                        dcyc[d] = n;
                    bs = n >= 2 && (dcyc[d] < 0 || n <= dcyc[d]);
                    check("busy", d, busy[d], bs);
                    if (val && dout_ready) begin
                        popped[d]++;
                        last_pop[d] = n;
                    end
                end
            end
            if (ab ? n >= rst_at + 8 : (dcyc[0] >= 0 && dcyc[1] >= 0 && n >= dcyc[0] + 3 && n >= dcyc[1] + 3))
                break;
        end
        cn = n;
        check("timeout", 0, n < 400, 1);
        if (rst_at < 0)
            for (int d = 0; d < 2; d++)
                check("word_count", d, popped[d], len);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        key = 1'b1;
        dout_ready = 1'b1;
        base_addr = '0;
        rd_len = '0;
        for (int i = 0; i < 32; i++)
            mem[i] = 16'(i + 100);
        for (int d = 0; d < 2; d++)
            last_a[d] = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_rd_en", d, rd_en[d], 0);
            check("reset_rd_addr", d, rd_addr[d], 0);
            check("reset_valid", d, dout_valid[d], 0);
            check("reset_dout", d, dout[d], 0);
            check("reset_busy", d, busy[d], 0);
            check("reset_done", d, done[d], 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++)
            check("idle_busy", d, busy[d], 0);
        run(3, 4, 0, -1, -1);
        run(30, 5, 0, -1, -1);
        run(7, 8, 1, -1, -1);
        run(0, 0, 0, 2, -1);
        run(10, 16, 0, 5, -1);
        run(5, 16, 0, -1, 8);
        run(12, 3, 0, -1, -1);
        for (int i = 0; i < 32; i++)
            mem[i] = 16'($urandom);
        run(0, 32, 0, -1, -1);
        repeat (8) begin
            for (int i = 0; i < 32; i++)
                mem[i] = 16'($urandom);
            run($urandom_range(0, 31), $urandom_range(0, 32), $urandom_range(0, 2), -1, -1);
        end
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
